// File: rtl/board_draw_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// draw_pkg
// Shared encodings for the board draw sequencer: job/grant codes, glyph
// symbol codes, screen geometry, FSM state encoding, the latched job record
// and the cell-number validity check.
// ----------------------------------------------------------------------------
package draw_pkg;

   // Job in service, also driven out on the grant port.
   typedef enum logic [1:0] {
      GRANT_NONE = 2'b00,
      GRANT_CLR  = 2'b01,
      GRANT_GRID = 2'b10,
      GRANT_CELL = 2'b11
   } grant_e;

   // Glyph symbol; the reserved code draws like an erase.
   typedef enum logic [1:0] {
      SYM_ERASE = 2'b00,
      SYM_X     = 2'b01,
      SYM_O     = 2'b10,
      SYM_RSVD  = 2'b11
   } sym_e;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Everything captured at acceptance; the requester may change its inputs
   // once the job has been taken.
   typedef struct packed {
      grant_e     job;
      logic [3:0] pos;
      sym_e       sym;
      logic [2:0] col;
   } job_t;

   // Cells are numbered 1..9; anything else is rejected without drawing.
   function automatic logic pos_valid(input logic [3:0] pos);
      return (pos != 4'd0) && (pos <= 4'd9);
   endfunction

endpackage

// File: rtl/board_draw_sequencer_if.sv
// ----------------------------------------------------------------------------
// board_draw_sequencer_if
// Request/status side (from the game control FSM) and plot side (to
// vga_adapter) of the board draw sequencer, bundled as one interface.
//   master : the controller/bench - drives requests, observes pixels/status
//   slave  : the sequencer        - reads requests, drives pixels/status
// Signals:
//   clr_req/grid_req/cell_req  level requests (clr > grid > cell)
//   cell_pos[3:0], cell_sym[1:0], cell_col[2:0]  glyph job operands
//   grid_col[2:0]              grid line colour
//   x[7:0], y[6:0], colour[2:0], plot   pixel write port
//   busy, done, err, grant[1:0]         job status
// ----------------------------------------------------------------------------
interface board_draw_sequencer_if;
   logic       clr_req;
   logic       grid_req;
   logic       cell_req;
   logic [3:0] cell_pos;
   logic [1:0] cell_sym;
   logic [2:0] cell_col;
   logic [2:0] grid_col;

   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] grant;

   modport master (
      output clr_req, grid_req, cell_req, cell_pos, cell_sym, cell_col, grid_col,
      input  x, y, colour, plot, busy, done, err, grant
   );

   modport slave (
      input  clr_req, grid_req, cell_req, cell_pos, cell_sym, cell_col, grid_col,
      output x, y, colour, plot, busy, done, err, grant
   );
endinterface

// File: rtl/board_draw_sequencer_cell_glyph.sv
// ----------------------------------------------------------------------------
// cell_glyph
// Combinational glyph shape: says whether pixel (i,j) of a GxG glyph box is
// lit for the given symbol. Kept separate so the shapes can be swapped.
// Ports:
//   sym_i[1:0]   symbol (erase / X / O / reserved=erase)
//   i_i[4:0]     x offset inside the glyph box
//   j_i[4:0]     y offset inside the glyph box
//   pixel_on_o   1 when the glyph covers this pixel
// ----------------------------------------------------------------------------
module cell_glyph
   import draw_pkg::*;
#(
   parameter int G = 24
) (
   input  logic [1:0] sym_i,
   input  logic [4:0] i_i,
   input  logic [4:0] j_i,
   output logic       pixel_on_o
);
   localparam logic [5:0] DIAG_SUM  = 6'(G - 1);
   localparam logic [4:0] EDGE_LO   = 5'd2;
   localparam logic [4:0] EDGE_HI   = 5'(G - 2);

   logic [5:0] ij_sum;
   logic       on_x;
   logic       on_o;

   assign ij_sum = {1'b0, i_i} + {1'b0, j_i};

   // X: both diagonals, one pixel wide.
   assign on_x = (i_i == j_i) || (ij_sum == DIAG_SUM);

   // O: a two-pixel-thick square ring on the box border.
   assign on_o = (i_i < EDGE_LO) || (i_i >= EDGE_HI) ||
                 (j_i < EDGE_LO) || (j_i >= EDGE_HI);

   always_comb begin
      pixel_on_o = 1'b0;
      case (sym_i)
         SYM_X:   pixel_on_o = on_x;
         SYM_O:   pixel_on_o = on_o;
         default: pixel_on_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/board_draw_sequencer.sv
// ----------------------------------------------------------------------------
// board_draw_sequencer
// Owns the vga_adapter plot port and arbitrates it between three level
// requesters: full-screen clear, board grid, single-cell glyph. An accepted
// job is scanned out one pixel per clock (inner loop x, outer loop y),
// followed by a one-cycle done pulse.
// Ports:
//   clock   system clock
//   resetn  synchronous, active-low reset
//   bus     board_draw_sequencer_if.slave (requests in, pixels/status out)
// Parameters:
//   BX0/BY0  board top-left corner, CELL cell pitch, INSET glyph inset
// ----------------------------------------------------------------------------
module board_draw_sequencer
   import draw_pkg::*;
#(
   parameter int BX0   = 32,
   parameter int BY0   = 12,
   parameter int CELL  = 32,
   parameter int INSET = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   board_draw_sequencer_if.slave bus
);
   localparam int G     = CELL - 2 * INSET;
   localparam int BOARD = 3 * CELL;

   // Last counter values per job type (scan box is W x H).
   localparam logic [7:0] CLR_LAST_I  = 8'(SCREEN_W - 1);
   localparam logic [6:0] CLR_LAST_J  = 7'(SCREEN_H - 1);
   localparam logic [7:0] GRID_LAST_I = 8'(BOARD - 1);
   localparam logic [6:0] GRID_LAST_J = 7'(BOARD - 1);
   localparam logic [7:0] CELL_LAST_I = 8'(G - 1);
   localparam logic [6:0] CELL_LAST_J = 7'(G - 1);

   // Inner grid lines sit on offsets CELL and 2*CELL of the board box.
   localparam logic [7:0] LINE1_I = 8'(CELL);
   localparam logic [7:0] LINE2_I = 8'(2 * CELL);
   localparam logic [6:0] LINE1_J = 7'(CELL);
   localparam logic [6:0] LINE2_J = 7'(2 * CELL);

   localparam logic [7:0] GRID_X0 = 8'(BX0);
   localparam logic [6:0] GRID_Y0 = 7'(BY0);

   // Glyph box origins per cell column / row.
   localparam logic [7:0] CX0 = 8'(BX0 + INSET);
   localparam logic [7:0] CX1 = 8'(BX0 + CELL + INSET);
   localparam logic [7:0] CX2 = 8'(BX0 + 2 * CELL + INSET);
   localparam logic [6:0] CY0 = 7'(BY0 + INSET);
   localparam logic [6:0] CY1 = 7'(BY0 + CELL + INSET);
   localparam logic [6:0] CY2 = 7'(BY0 + 2 * CELL + INSET);

   state_e     state_q, state_d;
   job_t       job_q, job_d;
   logic [7:0] i_q, i_d;
   logic [6:0] j_q, j_d;
   logic       err_q, err_d;
   logic [7:0] x_hold_q;
   logic [6:0] y_hold_q;
   logic [2:0] col_hold_q;

   logic       req_any;
   grant_e     req_job;
   logic       req_bad;
   logic [7:0] last_i;
   logic [6:0] last_j;
   logic       last_pix;
   logic [7:0] org_x;
   logic [6:0] org_y;
   logic       glyph_on;
   logic [7:0] scan_x;
   logic [6:0] scan_y;
   logic [2:0] scan_col;
   logic       scan_plot;

   // ------------------------------------------------------------------
   // Request arbitration: fixed priority clr > grid > cell.
   // ------------------------------------------------------------------
   always_comb begin
      req_any = bus.clr_req | bus.grid_req | bus.cell_req;
      req_job = GRANT_NONE;
      if (bus.clr_req)
         req_job = GRANT_CLR;
      else if (bus.grid_req)
         req_job = GRANT_GRID;
      else if (bus.cell_req)
         req_job = GRANT_CELL;
   end

   // A cell job with a bad number skips SCAN and goes straight to DONE.
   assign req_bad = (req_job == GRANT_CELL) && !pos_valid(bus.cell_pos);

   // ------------------------------------------------------------------
   // Scan box size for the job in service.
   // ------------------------------------------------------------------
   always_comb begin
      last_i = CLR_LAST_I;
      last_j = CLR_LAST_J;
      case (job_q.job)
         GRANT_GRID: begin
            last_i = GRID_LAST_I;
            last_j = GRID_LAST_J;
         end
         GRANT_CELL: begin
            last_i = CELL_LAST_I;
            last_j = CELL_LAST_J;
         end
         default: ;
      endcase
   end

   assign last_pix = (i_q == last_i) && (j_q == last_j);

   // ------------------------------------------------------------------
   // Cell number -> glyph box origin (table instead of a divide by 3).
   // ------------------------------------------------------------------
   always_comb begin
      org_x = CX0;
      org_y = CY0;
      case (job_q.pos)
         4'd1: begin org_x = CX0; org_y = CY0; end
         4'd2: begin org_x = CX1; org_y = CY0; end
         4'd3: begin org_x = CX2; org_y = CY0; end
         4'd4: begin org_x = CX0; org_y = CY1; end
         4'd5: begin org_x = CX1; org_y = CY1; end
         4'd6: begin org_x = CX2; org_y = CY1; end
         4'd7: begin org_x = CX0; org_y = CY2; end
         4'd8: begin org_x = CX1; org_y = CY2; end
         4'd9: begin org_x = CX2; org_y = CY2; end
         default: ;
      endcase
   end

   // Glyph counters never exceed G-1, so the low 5 bits are enough.
   cell_glyph #(
      .G (G)
   ) u_glyph (
      .sym_i      (job_q.sym),
      .i_i        (i_q[4:0]),
      .j_i        (j_q[4:0]),
      .pixel_on_o (glyph_on)
   );

   // ------------------------------------------------------------------
   // Pixel generator: combinational from latched job + counters.
   // ------------------------------------------------------------------
   always_comb begin
      scan_x    = i_q;
      scan_y    = j_q;
      scan_col  = 3'b000;
      scan_plot = 1'b1;
      case (job_q.job)
         GRANT_GRID: begin
            scan_x    = GRID_X0 + i_q;
            scan_y    = GRID_Y0 + j_q;
            scan_col  = job_q.col;
            scan_plot = (i_q == LINE1_I) || (i_q == LINE2_I) ||
                        (j_q == LINE1_J) || (j_q == LINE2_J);
         end
         GRANT_CELL: begin
            // Every box pixel is written so an old glyph is wiped.
            scan_x   = org_x + i_q;
            scan_y   = org_y + j_q;
            scan_col = glyph_on ? job_q.col : 3'b000;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register.
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // FSM: next state.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_any) state_d = req_bad ? ST_DONE : ST_SCAN;
         ST_SCAN: if (last_pix) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs. x/y/colour hold the last scanned pixel outside SCAN.
   // ------------------------------------------------------------------
   always_comb begin
      bus.x      = x_hold_q;
      bus.y      = y_hold_q;
      bus.colour = col_hold_q;
      bus.plot   = 1'b0;
      bus.busy   = (state_q != ST_IDLE);
      bus.done   = (state_q == ST_DONE);
      bus.err    = (state_q == ST_DONE) && err_q;
      bus.grant  = (state_q != ST_IDLE) ? job_q.job : GRANT_NONE;
      if (state_q == ST_SCAN) begin
         bus.x      = scan_x;
         bus.y      = scan_y;
         bus.colour = scan_col;
         bus.plot   = scan_plot;
      end
   end

   // ------------------------------------------------------------------
   // Job latch and scan counters.
   // ------------------------------------------------------------------
   always_comb begin
      job_d = job_q;
      i_d   = i_q;
      j_d   = j_q;
      err_d = err_q;
      if ((state_q == ST_IDLE) && req_any) begin
         job_d.job = req_job;
         job_d.pos = bus.cell_pos;
         job_d.sym = sym_e'(bus.cell_sym);
         case (req_job)
            GRANT_GRID: job_d.col = bus.grid_col;
            GRANT_CELL: job_d.col = bus.cell_col;
            default:    job_d.col = 3'b000;
         endcase
         i_d   = 8'd0;
         j_d   = 7'd0;
         err_d = req_bad;
      end else if (state_q == ST_SCAN) begin
         if (i_q == last_i) begin
            i_d = 8'd0;
            j_d = j_q + 7'd1;
         end else begin
            i_d = i_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         job_q      <= '{job: GRANT_NONE, pos: 4'd0, sym: SYM_ERASE, col: 3'd0};
         i_q        <= 8'd0;
         j_q        <= 7'd0;
         err_q      <= 1'b0;
         x_hold_q   <= 8'd0;
         y_hold_q   <= 7'd0;
         col_hold_q <= 3'd0;
      end else begin
         job_q <= job_d;
         i_q   <= i_d;
         j_q   <= j_d;
         err_q <= err_d;
         if (state_q == ST_SCAN) begin
            x_hold_q   <= scan_x;
            y_hold_q   <= scan_y;
            col_hold_q <= scan_col;
         end
      end
   end

endmodule
